// File: rtl/esp_tx_scheduler.sv
`timescale 1ns/1ps
// esp_tx_scheduler: round-robin arbiter that frames each request as header + payload
// and drives the shared ESP8266 SPI serializer one word at a time.
module esp_tx_scheduler #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 16,
   parameter int GAP_CYC    = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          spi_start,
   output logic [DATA_WIDTH-1:0]         spi_data,
   input  logic                          spi_done,
   output logic                          busy,
   output logic                          err,
   output logic [7:0]                    seq
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYC + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HDR_SEND = 3'd1,
      HDR_WAIT = 3'd2,
      DAT_SEND = 3'd3,
      DAT_WAIT = 3'd4,
      GAP      = 3'd5
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            gnt, gnt_nxt;
   logic [3:0]            rr_ptr, rr_ptr_nxt;
   logic [DATA_WIDTH-1:0] payload, payload_nxt;
   logic [DATA_WIDTH-1:0] spi_data_nxt;
   logic [TW-1:0]         to_cnt, to_cnt_nxt;
   logic [GW-1:0]         gap_cnt, gap_cnt_nxt;
   logic [NUM_REQ-1:0]    ack_nxt;
   logic                  spi_start_nxt;
   logic                  err_nxt;
   logic [7:0]            seq_nxt;

   // First requester found walking upward from ptr, wrapping modulo NUM_REQ.
   function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [3:0] ptr);
      logic [3:0]         res;
      logic               found;
      logic [NUM_REQ-1:0] tmp;
      int                 idx;
      res   = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr) + i) % NUM_REQ;
         tmp = r >> idx;
         if (!found && tmp[0]) begin
            res   = 4'(idx);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [3:0] rr_next(input logic [3:0] g);
      return (int'(g) == NUM_REQ - 1) ? 4'd0 : g + 4'd1;
   endfunction

   always_comb begin
      state_nxt     = state;
      gnt_nxt       = gnt;
      rr_ptr_nxt    = rr_ptr;
      payload_nxt   = payload;
      spi_data_nxt  = spi_data;
      to_cnt_nxt    = to_cnt;
      gap_cnt_nxt   = gap_cnt;
      ack_nxt       = '0;
      spi_start_nxt = 1'b0;
      err_nxt       = 1'b0;
      seq_nxt       = seq;

      case (state)
         IDLE: begin
            if (enable && (|req)) begin
               gnt_nxt     = rr_pick(req, rr_ptr);
               payload_nxt = DATA_WIDTH'(req_data >> (int'(gnt_nxt) * DATA_WIDTH));
               state_nxt   = HDR_SEND;
            end
         end
         HDR_SEND: begin
            spi_data_nxt  = DATA_WIDTH'({4'hA, gnt, seq});
            spi_start_nxt = 1'b1;
            to_cnt_nxt    = '0;
            state_nxt     = HDR_WAIT;
         end
         DAT_SEND: begin
            spi_data_nxt  = payload;
            spi_start_nxt = 1'b1;
            to_cnt_nxt    = '0;
            state_nxt     = DAT_WAIT;
         end
         HDR_WAIT, DAT_WAIT: begin
            // A done arriving on the timeout cycle still counts as success.
            if (spi_done) begin
               if (state == HDR_WAIT) begin
                  state_nxt = DAT_SEND;
               end else begin
                  ack_nxt     = NUM_REQ'(1) << gnt;
                  seq_nxt     = seq + 8'd1;
                  rr_ptr_nxt  = rr_next(gnt);
                  gap_cnt_nxt = '0;
                  state_nxt   = GAP;
               end
            end else if (to_cnt == TW'(TIMEOUT - 1)) begin
               err_nxt     = 1'b1;
               rr_ptr_nxt  = rr_next(gnt);
               gap_cnt_nxt = '0;
               state_nxt   = GAP;
            end else begin
               to_cnt_nxt = to_cnt + TW'(1);
            end
         end
         GAP: begin
            if (gap_cnt == GW'(GAP_CYC - 1)) begin
               state_nxt = IDLE;
            end else begin
               gap_cnt_nxt = gap_cnt + GW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         gnt       <= '0;
         rr_ptr    <= '0;
         spi_data  <= '0;
         to_cnt    <= '0;
         gap_cnt   <= '0;
         ack       <= '0;
         spi_start <= 1'b0;
         err       <= 1'b0;
         seq       <= '0;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         rr_ptr    <= rr_ptr_nxt;
         spi_data  <= spi_data_nxt;
         to_cnt    <= to_cnt_nxt;
         gap_cnt   <= gap_cnt_nxt;
         ack       <= ack_nxt;
         spi_start <= spi_start_nxt;
         err       <= err_nxt;
         seq       <= seq_nxt;
      end
   end

   // Payload is only consumed after a grant, so it needs no reset.
   always_ff @(posedge clk) begin
      payload <= payload_nxt;
   end

   assign busy = (state != IDLE);

endmodule
